// File: rtl/inst_tlb_responder_if.sv
// Instruction-side TLB lookup and CP0 write bundle.
// The master is the MMU/CP0 side; the slave is the TLB responder.
interface inst_tlb_responder_if;
  logic        inst_tlbReq_i;
  logic [18:0] inst_vpn2_i;
  logic        inst_oddPage_i;
  logic [7:0]  inst_asid_i;

  logic        inst_rspValid_o;
  logic        inst_hit_o;
  logic [3:0]  inst_index_o;
  logic [19:0] inst_pfn_o;
  logic [2:0]  inst_c_o;
  logic        inst_d_o;
  logic        inst_v_o;
  logic        inst_lastHit_o;

  logic        tlbWe_i;
  logic [3:0]  tlbWIndex_i;
  logic [18:0] tlbWVpn2_i;
  logic [7:0]  tlbWAsid_i;
  logic        tlbWG_i;
  logic [19:0] tlbWPfn0_i;
  logic [19:0] tlbWPfn1_i;
  logic [2:0]  tlbWC0_i;
  logic [2:0]  tlbWC1_i;
  logic        tlbWD0_i;
  logic        tlbWD1_i;
  logic        tlbWV0_i;
  logic        tlbWV1_i;
  logic        tlbFlush_i;

  modport master (
    output inst_tlbReq_i, inst_vpn2_i, inst_oddPage_i, inst_asid_i,
    input  inst_rspValid_o, inst_hit_o, inst_index_o, inst_pfn_o,
    input  inst_c_o, inst_d_o, inst_v_o, inst_lastHit_o,
    output tlbWe_i, tlbWIndex_i, tlbWVpn2_i, tlbWAsid_i, tlbWG_i,
    output tlbWPfn0_i, tlbWPfn1_i, tlbWC0_i, tlbWC1_i,
    output tlbWD0_i, tlbWD1_i, tlbWV0_i, tlbWV1_i, tlbFlush_i
  );

  modport slave (
    input  inst_tlbReq_i, inst_vpn2_i, inst_oddPage_i, inst_asid_i,
    output inst_rspValid_o, inst_hit_o, inst_index_o, inst_pfn_o,
    output inst_c_o, inst_d_o, inst_v_o, inst_lastHit_o,
    input  tlbWe_i, tlbWIndex_i, tlbWVpn2_i, tlbWAsid_i, tlbWG_i,
    input  tlbWPfn0_i, tlbWPfn1_i, tlbWC0_i, tlbWC1_i,
    input  tlbWD0_i, tlbWD1_i, tlbWV0_i, tlbWV1_i, tlbFlush_i
  );
endinterface

// File: rtl/inst_tlb_responder.sv
// 16-entry instruction TLB with a one-cycle registered lookup response.
// Optional last-hit register enabled by defining TLB_LAST_HIT_EN.
module inst_tlb_responder (
  input  logic                 clk,
  input  logic                 rst,
  inst_tlb_responder_if.slave  tlb
);
  localparam int ENTRIES = 16;

  logic [ENTRIES-1:0] present_q;
  logic [18:0] vpn2_q [ENTRIES];
  logic [7:0]  asid_q [ENTRIES];
  logic        g_q    [ENTRIES];
  logic [19:0] pfn0_q [ENTRIES];
  logic [19:0] pfn1_q [ENTRIES];
  logic [2:0]  c0_q   [ENTRIES];
  logic [2:0]  c1_q   [ENTRIES];
  logic        d0_q   [ENTRIES];
  logic        d1_q   [ENTRIES];
  logic        v0_q   [ENTRIES];
  logic        v1_q   [ENTRIES];

  // Present bits: flush clears all, a same-edge write then re-marks its entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      present_q <= '0;
    end else begin
      if (tlb.tlbFlush_i) present_q <= '0;
      if (tlb.tlbWe_i)    present_q[tlb.tlbWIndex_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tlb.tlbWe_i) begin
      vpn2_q[tlb.tlbWIndex_i] <= tlb.tlbWVpn2_i;
      asid_q[tlb.tlbWIndex_i] <= tlb.tlbWAsid_i;
      g_q[tlb.tlbWIndex_i]    <= tlb.tlbWG_i;
      pfn0_q[tlb.tlbWIndex_i] <= tlb.tlbWPfn0_i;
      pfn1_q[tlb.tlbWIndex_i] <= tlb.tlbWPfn1_i;
      c0_q[tlb.tlbWIndex_i]   <= tlb.tlbWC0_i;
      c1_q[tlb.tlbWIndex_i]   <= tlb.tlbWC1_i;
      d0_q[tlb.tlbWIndex_i]   <= tlb.tlbWD0_i;
      d1_q[tlb.tlbWIndex_i]   <= tlb.tlbWD1_i;
      v0_q[tlb.tlbWIndex_i]   <= tlb.tlbWV0_i;
      v1_q[tlb.tlbWIndex_i]   <= tlb.tlbWV1_i;
    end
  end

  // Stage p0: associative match against pre-write array contents.
  logic [ENTRIES-1:0] match_p0;
  logic        arr_hit_p0;
  logic [3:0]  arr_idx_p0;
  logic [19:0] arr_pfn_p0;
  logic [2:0]  arr_c_p0;
  logic        arr_d_p0;
  logic        arr_v_p0;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      match_p0[i] = present_q[i] && (vpn2_q[i] == tlb.inst_vpn2_i) &&
                    (g_q[i] || (asid_q[i] == tlb.inst_asid_i));
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    arr_hit_p0 = 1'b0;
    arr_idx_p0 = '0;
    arr_pfn_p0 = '0;
    arr_c_p0   = '0;
    arr_d_p0   = 1'b0;
    arr_v_p0   = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_p0[i]) begin
        arr_hit_p0 = 1'b1;
        arr_idx_p0 = 4'(i);
      end
    end
    if (arr_hit_p0) begin
      arr_pfn_p0 = tlb.inst_oddPage_i ? pfn1_q[arr_idx_p0] : pfn0_q[arr_idx_p0];
      arr_c_p0   = tlb.inst_oddPage_i ? c1_q[arr_idx_p0]   : c0_q[arr_idx_p0];
      arr_d_p0   = tlb.inst_oddPage_i ? d1_q[arr_idx_p0]   : d0_q[arr_idx_p0];
      arr_v_p0   = tlb.inst_oddPage_i ? v1_q[arr_idx_p0]   : v0_q[arr_idx_p0];
    end
  end

  logic        sel_hit_p0;
  logic [3:0]  sel_idx_p0;
  logic [19:0] sel_pfn_p0;
  logic [2:0]  sel_c_p0;
  logic        sel_d_p0;
  logic        sel_v_p0;
  logic        sel_lh_p0;

`ifdef TLB_LAST_HIT_EN
  logic        lh_vld_q;
  logic [18:0] lh_vpn2_q;
  logic        lh_odd_q;
  logic [7:0]  lh_asid_q;
  logic [3:0]  lh_idx_q;
  logic [19:0] lh_pfn_q;
  logic [2:0]  lh_c_q;
  logic        lh_d_q;
  logic        lh_v_q;

  assign sel_lh_p0 = lh_vld_q && (lh_vpn2_q == tlb.inst_vpn2_i) &&
                     (lh_odd_q == tlb.inst_oddPage_i) && (lh_asid_q == tlb.inst_asid_i);

  assign sel_hit_p0 = sel_lh_p0 ? 1'b1     : arr_hit_p0;
  assign sel_idx_p0 = sel_lh_p0 ? lh_idx_q : arr_idx_p0;
  assign sel_pfn_p0 = sel_lh_p0 ? lh_pfn_q : arr_pfn_p0;
  assign sel_c_p0   = sel_lh_p0 ? lh_c_q   : arr_c_p0;
  assign sel_d_p0   = sel_lh_p0 ? lh_d_q   : arr_d_p0;
  assign sel_v_p0   = sel_lh_p0 ? lh_v_q   : arr_v_p0;

  // Any array modification makes the cached result stale, even on a same-edge hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lh_vld_q  <= 1'b0;
      lh_vpn2_q <= '0;
      lh_odd_q  <= 1'b0;
      lh_asid_q <= '0;
      lh_idx_q  <= '0;
      lh_pfn_q  <= '0;
      lh_c_q    <= '0;
      lh_d_q    <= 1'b0;
      lh_v_q    <= 1'b0;
    end else if (tlb.tlbWe_i || tlb.tlbFlush_i) begin
      lh_vld_q <= 1'b0;
    end else if (tlb.inst_tlbReq_i && sel_hit_p0) begin
      lh_vld_q  <= 1'b1;
      lh_vpn2_q <= tlb.inst_vpn2_i;
      lh_odd_q  <= tlb.inst_oddPage_i;
      lh_asid_q <= tlb.inst_asid_i;
      lh_idx_q  <= sel_idx_p0;
      lh_pfn_q  <= sel_pfn_p0;
      lh_c_q    <= sel_c_p0;
      lh_d_q    <= sel_d_p0;
      lh_v_q    <= sel_v_p0;
    end
  end
`else
  assign sel_lh_p0  = 1'b0;
  assign sel_hit_p0 = arr_hit_p0;
  assign sel_idx_p0 = arr_idx_p0;
  assign sel_pfn_p0 = arr_pfn_p0;
  assign sel_c_p0   = arr_c_p0;
  assign sel_d_p0   = arr_d_p0;
  assign sel_v_p0   = arr_v_p0;
`endif

  // Stage p1: registered response, held between requests.
  logic        vld_p1;
  logic        hit_p1;
  logic [3:0]  idx_p1;
  logic [19:0] pfn_p1;
  logic [2:0]  c_p1;
  logic        d_p1;
  logic        v_p1;
  logic        lh_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      hit_p1 <= 1'b0;
      idx_p1 <= '0;
      pfn_p1 <= '0;
      c_p1   <= '0;
      d_p1   <= 1'b0;
      v_p1   <= 1'b0;
      lh_p1  <= 1'b0;
    end else begin
      vld_p1 <= tlb.inst_tlbReq_i;
      if (tlb.inst_tlbReq_i) begin
        hit_p1 <= sel_hit_p0;
        idx_p1 <= sel_idx_p0;
        pfn_p1 <= sel_pfn_p0;
        c_p1   <= sel_c_p0;
        d_p1   <= sel_d_p0;
        v_p1   <= sel_v_p0;
        lh_p1  <= sel_lh_p0;
      end
    end
  end

  assign tlb.inst_rspValid_o = vld_p1;
  assign tlb.inst_hit_o      = hit_p1;
  assign tlb.inst_index_o    = idx_p1;
  assign tlb.inst_pfn_o      = pfn_p1;
  assign tlb.inst_c_o        = c_p1;
  assign tlb.inst_d_o        = d_p1;
  assign tlb.inst_v_o        = v_p1;
  assign tlb.inst_lastHit_o  = lh_p1;
endmodule

// File: tb/tb_inst_tlb_responder.sv
// Scoreboard bench for inst_tlb_responder: directed lookups, writes and flushes.
module tb_inst_tlb_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_tlb_responder_if tb_if ();
  inst_tlb_responder dut (.clk(clk), .rst(rst), .tlb(tb_if));

`ifdef TLB_LAST_HIT_EN
  localparam logic LH = 1'b1;
`else
  localparam logic LH = 1'b0;
`endif

  typedef struct packed {
    logic        hit;
    logic [3:0]  idx;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        lh;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rsp_n  = 0;

  function automatic rsp_t mk(input logic hit, input logic [3:0] idx, input logic [19:0] pfn,
                              input logic [2:0] c, input logic d, input logic v, input logic lh);
    rsp_t r;
    r.hit = hit; r.idx = idx; r.pfn = pfn; r.c = c; r.d = d; r.v = v; r.lh = lh;
    return r;
  endfunction

  function automatic rsp_t miss();
    return mk(1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    tb_if.inst_tlbReq_i = 1'b0;
    tb_if.tlbWe_i       = 1'b0;
    tb_if.tlbFlush_i    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                    input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                    input logic d0, input logic v0, input logic [19:0] pfn1,
                    input logic [2:0] c1, input logic d1, input logic v1);
    tb_if.tlbWe_i     = 1'b1;
    tb_if.tlbWIndex_i = idx;
    tb_if.tlbWVpn2_i  = vpn2;
    tb_if.tlbWAsid_i  = asid;
    tb_if.tlbWG_i     = g;
    tb_if.tlbWPfn0_i  = pfn0;
    tb_if.tlbWC0_i    = c0;
    tb_if.tlbWD0_i    = d0;
    tb_if.tlbWV0_i    = v0;
    tb_if.tlbWPfn1_i  = pfn1;
    tb_if.tlbWC1_i    = c1;
    tb_if.tlbWD1_i    = d1;
    tb_if.tlbWV1_i    = v1;
  endtask

  task automatic req(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid,
                     input rsp_t exp);
    tb_if.inst_tlbReq_i  = 1'b1;
    tb_if.inst_vpn2_i    = vpn2;
    tb_if.inst_oddPage_i = odd;
    tb_if.inst_asid_i    = asid;
    exp_q.push_back(exp);
  endtask

  // Monitor: every presented response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (tb_if.inst_rspValid_o === 1'b1) begin
      rsp_t act;
      rsp_t e;
      act = mk(tb_if.inst_hit_o, tb_if.inst_index_o, tb_if.inst_pfn_o, tb_if.inst_c_o,
               tb_if.inst_d_o, tb_if.inst_v_o, tb_if.inst_lastHit_o);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp%0d unexpected: hit=%0b idx=%0d pfn=%h", rsp_n, act.hit, act.idx, act.pfn);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL rsp%0d: got hit=%0b idx=%0d pfn=%h c=%0d d=%0b v=%0b lh=%0b, expected hit=%0b idx=%0d pfn=%h c=%0d d=%0b v=%0b lh=%0b",
                   rsp_n, act.hit, act.idx, act.pfn, act.c, act.d, act.v, act.lh,
                   e.hit, e.idx, e.pfn, e.c, e.d, e.v, e.lh);
        end
      end
      rsp_n++;
    end
  end

  initial begin
    rst = 1'b0;
    clr();
    tb_if.inst_vpn2_i = '0; tb_if.inst_oddPage_i = 1'b0; tb_if.inst_asid_i = '0;
    wr(4'd0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    tb_if.tlbWe_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rspValid", 32'(tb_if.inst_rspValid_o), 32'd0);
    chk("reset_hit",      32'(tb_if.inst_hit_o),      32'd0);
    chk("reset_index",    32'(tb_if.inst_index_o),    32'd0);
    chk("reset_pfn",      32'(tb_if.inst_pfn_o),      32'd0);
    chk("reset_lastHit",  32'(tb_if.inst_lastHit_o),  32'd0);
    rst = 1'b1;
    step();

    // Empty TLB misses.
    req(19'h00001, 1'b0, 8'h05, miss()); step();

    // Entry 3, page-specific fields, ASID and global matching.
    wr(4'd3, 19'h12345, 8'h05, 1'b0, 20'h11111, 3'd2, 1'b0, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1); step();
    req(19'h12345, 1'b1, 8'h05, mk(1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b0)); step();
    req(19'h12345, 1'b0, 8'h05, mk(1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b1, 1'b0)); step();
    req(19'h12345, 1'b1, 8'h06, miss()); step();
    step();
    wr(4'd3, 19'h12345, 8'h05, 1'b1, 20'h11111, 3'd2, 1'b0, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1); step();
    req(19'h12345, 1'b1, 8'h06, mk(1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b0)); step();

    // Entries 2 and 9 both match: lowest index wins; only global 9 for other ASID.
    wr(4'd9, 19'h00ABC, 8'h01, 1'b1, 20'h99999, 3'd1, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0); step();
    wr(4'd2, 19'h00ABC, 8'h01, 1'b0, 20'h22222, 3'd4, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0); step();
    req(19'h00ABC, 1'b0, 8'h01, mk(1'b1, 4'd2, 20'h22222, 3'd4, 1'b0, 1'b1, 1'b0)); step();
    req(19'h00ABC, 1'b0, 8'h02, mk(1'b1, 4'd9, 20'h99999, 3'd1, 1'b1, 1'b1, 1'b0)); step();

    // Same-edge write and lookup sees old contents.
    wr(4'd4, 19'h7FFFF, 8'h10, 1'b0, 20'hFFFFF, 3'd7, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    req(19'h7FFFF, 1'b0, 8'h10, miss()); step();
    req(19'h7FFFF, 1'b0, 8'h10, mk(1'b1, 4'd4, 20'hFFFFF, 3'd7, 1'b1, 1'b1, 1'b0)); step();

    // Repeated lookups use the last-hit register; a write invalidates it.
    req(19'h7FFFF, 1'b0, 8'h10, mk(1'b1, 4'd4, 20'hFFFFF, 3'd7, 1'b1, 1'b1, LH)); step();
    req(19'h7FFFF, 1'b0, 8'h10, mk(1'b1, 4'd4, 20'hFFFFF, 3'd7, 1'b1, 1'b1, LH)); step();
    wr(4'd5, 19'h00055, 8'h00, 1'b0, 20'h55555, 3'd5, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0); step();
    req(19'h7FFFF, 1'b0, 8'h10, mk(1'b1, 4'd4, 20'hFFFFF, 3'd7, 1'b1, 1'b1, 1'b0)); step();
    req(19'h7FFFF, 1'b0, 8'h10, mk(1'b1, 4'd4, 20'hFFFFF, 3'd7, 1'b1, 1'b1, LH)); step();

    // Flush clears everything, including the cached hit.
    tb_if.tlbFlush_i = 1'b1; step();
    req(19'h12345, 1'b1, 8'h05, miss()); step();
    req(19'h7FFFF, 1'b0, 8'h10, miss()); step();

    // Flush plus write: only the written entry survives.
    tb_if.tlbFlush_i = 1'b1;
    wr(4'd7, 19'h00777, 8'h03, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h77777, 3'd5, 1'b0, 1'b1); step();
    req(19'h00777, 1'b1, 8'h03, mk(1'b1, 4'd7, 20'h77777, 3'd5, 1'b0, 1'b1, 1'b0)); step();
    req(19'h00ABC, 1'b0, 8'h01, miss()); step();

    // Lookup at the flush edge returns pre-flush contents.
    tb_if.tlbFlush_i = 1'b1;
    req(19'h00777, 1'b1, 8'h03, mk(1'b1, 4'd7, 20'h77777, 3'd5, 1'b0, 1'b1, LH)); step();
    req(19'h00777, 1'b1, 8'h03, miss()); step();

    // Reset during a pending response suppresses it; the TLB is empty afterwards.
    wr(4'd1, 19'h00111, 8'h00, 1'b1, 20'h11AAA, 3'd6, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0); step();
    req(19'h00111, 1'b0, 8'h09, mk(1'b1, 4'd1, 20'h11AAA, 3'd6, 1'b1, 1'b1, 1'b0)); step();
    tb_if.inst_tlbReq_i = 1'b1;
    @(posedge clk);
    #1;
    clr();
    rst = 1'b0;
    #1;
    chk("midreset_rspValid", 32'(tb_if.inst_rspValid_o), 32'd0);
    chk("midreset_hit",      32'(tb_if.inst_hit_o),      32'd0);
    chk("midreset_pfn",      32'(tb_if.inst_pfn_o),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    req(19'h00111, 1'b0, 8'h09, miss()); step();

    repeat (3) step();
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_tlb_responder.md
INST_TLB_RESPONDER -- requirements
Module: inst_tlb_responder

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port inst_tlbReq_i  in  1  lookup request strobe from instruction MMU.
REQ-004 SHALL have port inst_vpn2_i  in  19  VA[31:13].
REQ-005 SHALL have port inst_oddPage_i  in  1  VA[12], selects page 1 when set.
REQ-006 SHALL have port inst_asid_i  in  8  current ASID.
REQ-007 SHALL have port inst_rspValid_o  out  1  response valid.
REQ-008 SHALL have port inst_hit_o  out  1  a matching entry exists.
REQ-009 SHALL have port inst_index_o  out  4  matching entry index.
REQ-010 SHALL have port inst_pfn_o  out  20  selected page frame number.
REQ-011 SHALL have port inst_c_o  out  3  cache attribute.
REQ-012 SHALL have port inst_d_o  out  1  dirty bit; inst_v_o  out  1  valid bit.
REQ-013 SHALL have port inst_lastHit_o  out  1  response served from last-hit register.
REQ-014 SHALL have write port tlbWe_i 1, tlbWIndex_i 4, tlbWVpn2_i 19, tlbWAsid_i 8, tlbWG_i 1, tlbWPfn0_i/tlbWPfn1_i 20, tlbWC0_i/tlbWC1_i 3, tlbWD0_i/tlbWD1_i 1, tlbWV0_i/tlbWV1_i 1 (all inputs, from CP0 on TLBWI/TLBWR).
REQ-015 SHALL have port tlbFlush_i  in  1  invalidate all entries.

Function
REQ-016 SHALL hold 16 entries {present, vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}.
REQ-017 Entry matches SHALL be: present && vpn2 equal && (g || asid equal).
REQ-018 On inst_tlbReq_i high at edge N, the response SHALL be registered and visible during cycle N+1 with inst_rspValid_o=1; rspValid SHALL be 0 in any cycle not following a request.
REQ-019 Outputs SHALL hold their last values when rspValid is 0.
REQ-020 Multiple matches SHALL resolve to the lowest index.
REQ-021 On miss: hit=0, index=0, pfn=0, c=0, d=0, v=0.
REQ-022 On hit: pfn/c/d/v SHALL come from the page-1 fields if oddPage else page-0 fields.
REQ-023 tlbWe_i SHALL write all fields of entry tlbWIndex_i and set present=1 at the edge.
REQ-024 Lookup and write at the same edge SHALL return pre-write contents; a lookup at the following edge SHALL see the new entry.
REQ-025 tlbFlush_i SHALL clear every present bit at the edge; flush and write at the same edge SHALL leave only the written entry present.
REQ-026 A lookup at the same edge as a flush SHALL return pre-flush contents.

Reset
REQ-027 Asserting rst SHALL immediately clear all present bits, rspValid, hit, index, pfn, c, d, v, lastHit and the last-hit register; other entry fields are unreset.
REQ-028 Reset asserted mid-lookup SHALL suppress the pending response; the first request after deassertion SHALL miss.

Configuration
REQ-029 Macro TLB_LAST_HIT_EN SHALL be the only compile option.
REQ-030 With TLB_LAST_HIT_EN defined: a register SHALL hold {key vpn2, oddPage, asid, result} of the last hitting lookup; a request matching the key while the register is valid SHALL be answered from it with lastHit=1; any write or flush SHALL invalidate it at the same edge; response values SHALL be identical to the array result.
REQ-031 Without TLB_LAST_HIT_EN: no last-hit register, inst_lastHit_o tied 0.

Verification
REQ-032 Reset, request vpn2=0x00001, asid=0x05 -> cycle N+1 rspValid=1, hit=0, all fields 0.
REQ-033 Write idx 3 {vpn2=0x12345, asid=0x05, g=0, pfn1=0xABCDE, c1=3, d1=1, v1=1}, request same vpn2, oddPage=1, asid=0x05 -> hit=1, index=3, pfn=0xABCDE, c=3, d=1, v=1; with asid=0x06 -> hit=0; set g=1 -> hit=1.
REQ-034 Entries 2 and 9 both matching -> index=2.
REQ-035 Write idx 4 and request its vpn2 at the same edge -> miss; repeat next cycle -> hit index=4.
REQ-036 Flush after REQ-033 entry present -> next lookup misses; flush+write idx 7 same edge -> only idx 7 hits.
REQ-037 TLB_LAST_HIT_EN: two identical back-to-back hitting requests -> second has lastHit=1 with same values; interpose a write -> lastHit=0.
